vga_tile_src: RTL and testbench
===============================

Name: vga_tile_src

Overview:
- Pixel source feeding the VGA controller: turns the controller's row_addr/col_addr/rdn into an 8-bit rrr_ggg_bb pixel (d_out → controller d_in).
- Holds an 80x60 solid-colour tile map (8x8 px tiles) and one 16x16 sprite, both written by the CPU through a simple memory-mapped port.
- Detects frame boundaries from the controller's rdn/row_addr and updates sprite registers only during vertical blank. This keeps motion tear-free and gives the CPU a frame counter and vblank status.

Parameters:
- H_PIX, 640, visible columns
- V_PIX, 480, visible rows
- TILE_W, 80, tiles per row (H_PIX/8)
- SPR_SIZE, 16, sprite edge length in pixels

Ports:
- vga_clk  in  1  25 MHz pixel clock; the CPU port is on this same clock
- rst  in  1  synchronous reset, active-high
- row_addr  in  9  controller pixel row
- col_addr  in  10  controller pixel column
- rdn  in  1  controller read strobe, active low
- d_out  out  8  pixel rrr_ggg_bb, combinational from the address inputs
- cpu_we  in  1  write strobe, one-cycle pulse
- cpu_addr  in  13  0x0000–0x12BF tile map; 0x1800–0x1803 registers
- cpu_wdata  in  16  write data
- cpu_rdata  out  16  read data, registered
- vblank  out  1  high from vblank start to vblank end

Behaviour:
- Reset (rst=1 at a vga_clk edge) clears the following:
  - cpu_rdata=0 and vblank=0.
  - Frame counter=0 and sticky flag=0.
  - Pending and active sprite registers=0, so the sprite is disabled.
  - The tile map RAM is not cleared.
  - Reset mid-frame leaves d_out showing tile data immediately.
- Pixel path is zero latency, because the controller samples d_in in the cycle after it registers the addresses:
  - rdn=1 → d_out=8'h00.
  - Otherwise, sprite hit → d_out = active sprite colour.
  - Sprite hit: spr_en=1, spr_x ≤ col_addr < spr_x+16, and spr_y ≤ row_addr < spr_y+16. Compare in 11 bits so no wrap occurs; a sprite partially off-screen clips.
  - No sprite hit → d_out = tile_map[row_addr[8:3]*80 + col_addr[9:3]].
  - The index is computed as (r<<6)+(r<<4)+c, 13-bit.
  - Tile map is asynchronous-read distributed RAM.
- Frame detection uses an internal rdn_q register (reset value 1):
  - vblank_start = rdn_q=0 & rdn=1 & row_addr=479.
  - vblank_end = rdn_q=1 & rdn=0 & row_addr=0.
  - vblank is set on vblank_start and cleared on vblank_end.
  - On vblank_start:
    - frame counter (8-bit, wraps 255→0) increments;
    - pending sprite registers copy to active;
    - sticky flag sets.
- CPU writes (cpu_we=1, one cycle, no wait states):
  - Tile map: tile_map[cpu_addr] ← cpu_wdata[7:0]. A video read of the same address in the same cycle returns the old value.
  - 0x1800: pending spr_x ← wdata[9:0].
  - 0x1801: pending spr_y ← wdata[8:0].
  - 0x1802: pending spr_color ← wdata[7:0], pending spr_en ← wdata[8].
  - 0x1803: any write clears the sticky flag. A clear coinciding with vblank_start loses: the flag stays set.
  - Writes to 0x12C0–0x17FF and 0x1804–0x1FFF are ignored.
  - A pending write in the same cycle as vblank_start is captured in pending only; it reaches active at the next vblank_start.
- CPU reads:
  - cpu_rdata is registered every cycle from cpu_addr, giving 1-cycle latency.
  - Tile map → {8'h0, entry}.
  - 0x1800–0x1802 return the pending values, zero-extended.
  - 0x1803 returns {6'h0, vblank, sticky, frame_cnt}.
  - Unmapped addresses return 0.

Optional Feature:
- Macro: VGA_FRAME_IRQ_EN.
- Defined: adds output irq (1 bit), reset 0.
  - irq is set on vblank_start.
  - It is cleared by a CPU write of wdata[0]=1 to 0x1803. Set wins if both occur in the same cycle.
  - Reading 0x1803 additionally returns irq in bit 10.
- Undefined: no irq port, and bit 10 reads 0.

Test Plan:
- Reset behaviour: rst for 2 cycles; write tile 0 = 8'hE0; drive rdn=0, row=0, col=5 → d_out=8'hE0. Drive rdn=1 → d_out=8'h00.
- Tile indexing: write tile 4799 = 8'h1C, then drive row=479, col=639 → 8'h1C. Drive row=8, col=0 → reads index 80.
- Sprite double-buffering:
  - Write spr_x=100, spr_y=50, 0x1802=0x1FF mid-frame → row=50, col=100 still shows the tile.
  - After vblank_start → d_out=8'hFF at (50,100) and (65,115); tile shows at (66,116).
- Sprite clipping: spr_x=630 → pixels 630–639 show the sprite; no wrap to columns 0–5.
- Frame counter and status:
  - Run 3 full frames (800x525 cycles each) → frame_cnt=3, sticky=1.
  - Write 0x1803 → sticky=0. Read 0x1803 → value valid one cycle later.
- Coincident-event boundaries:
  - Write 0x1803 in the vblank_start cycle → sticky stays 1.
  - With VGA_FRAME_IRQ_EN: irq rises in the same cycle.
  - An ack with wdata[0]=1 in that same cycle leaves irq=1.

Source files
------------

// File: rtl/vga_tile_src.sv
// rtl/vga_tile_src.sv - tile-map + sprite pixel source for the VGA controller (optional VGA_FRAME_IRQ_EN frame irq)
// Sprite position/colour are double-buffered and only take effect at vblank start.
module vga_tile_src #(
   parameter int H_PIX    = 640,
   parameter int V_PIX    = 480,
   parameter int TILE_W   = 80,
   parameter int SPR_SIZE = 16
) (
   input  logic        vga_clk,
   input  logic        rst,
   input  logic [8:0]  row_addr,
   input  logic [9:0]  col_addr,
   input  logic        rdn,
   output logic [7:0]  d_out,
   input  logic        cpu_we,
   input  logic [12:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        vblank
`ifdef VGA_FRAME_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int          TILES    = TILE_W * (V_PIX / 8);
   localparam logic [12:0] TILE_LIM = 13'(TILES);
   localparam logic [9:0]  H_LIM    = 10'(H_PIX);
   localparam logic [8:0]  V_LIM    = 9'(V_PIX);
   localparam logic [8:0]  V_LAST   = 9'(V_PIX - 1);
   localparam logic [10:0] SPR_LEN  = 11'(SPR_SIZE);
   localparam logic [12:0] A_SPR_X  = 13'h1800;
   localparam logic [12:0] A_SPR_Y  = 13'h1801;
   localparam logic [12:0] A_SPR_C  = 13'h1802;
   localparam logic [12:0] A_STAT   = 13'h1803;

   typedef struct packed {
      logic       en;
      logic [7:0] color;
      logic [8:0] y;
      logic [9:0] x;
   } spr_t;

   logic [7:0]  tile_map [TILES];
   spr_t        spr_pend;
   spr_t        spr_act;
   logic        rdn_q;
   logic        sticky;
   logic [7:0]  frame_cnt;
   logic        vblank_start;
   logic        vblank_end;
   logic        stat_wr;
   logic        irq_bit;
   logic [12:0] row_term;
   logic [12:0] tile_idx;
   logic        tile_vis;
   logic        spr_hit;
   logic [10:0] col_w;
   logic [10:0] row_w;
   logic [10:0] spr_x_w;
   logic [10:0] spr_y_w;
   logic [15:0] rd_mux;
   logic        unused_wdata;

   assign unused_wdata = ^cpu_wdata[15:10];

   assign vblank_start = !rdn_q && rdn && (row_addr == V_LAST);
   assign vblank_end   = rdn_q && !rdn && (row_addr == 9'd0);
   assign stat_wr      = cpu_we && (cpu_addr == A_STAT);

   // Zero-latency pixel path: the controller samples d_in one cycle after it registers the address.
   always_comb begin
      row_term = {7'd0, row_addr[8:3]};
      tile_idx = (row_term << 6) + (row_term << 4) + {6'd0, col_addr[9:3]};
      tile_vis = (row_addr < V_LIM) && (col_addr < H_LIM);
      col_w    = {1'b0, col_addr};
      row_w    = {2'b0, row_addr};
      spr_x_w  = {1'b0, spr_act.x};
      spr_y_w  = {2'b0, spr_act.y};
      spr_hit  = spr_act.en &&
                 (col_w >= spr_x_w) && (col_w < spr_x_w + SPR_LEN) &&
                 (row_w >= spr_y_w) && (row_w < spr_y_w + SPR_LEN);
      d_out    = 8'h00;
      if (!rdn) begin
         if (spr_hit)
            d_out = spr_act.color;
         else if (tile_vis)
            d_out = tile_map[tile_idx];
      end
   end

   // Tile RAM is never reset so the picture survives a mid-frame reset.
   always_ff @(posedge vga_clk) begin
      if (cpu_we && (cpu_addr < TILE_LIM))
         tile_map[cpu_addr] <= cpu_wdata[7:0];
   end

`ifdef VGA_FRAME_IRQ_EN
   always_ff @(posedge vga_clk) begin
      if (rst)
         irq <= 1'b0;
      else if (vblank_start)
         irq <= 1'b1;
      else if (stat_wr && cpu_wdata[0])
         irq <= 1'b0;
   end
   assign irq_bit = irq;
`else
   assign irq_bit = 1'b0;
`endif

   always_comb begin
      rd_mux = 16'h0000;
      if (cpu_addr < TILE_LIM)
         rd_mux = {8'h00, tile_map[cpu_addr]};
      else begin
         case (cpu_addr)
            A_SPR_X: rd_mux = {6'h00, spr_pend.x};
            A_SPR_Y: rd_mux = {7'h00, spr_pend.y};
            A_SPR_C: rd_mux = {7'h00, spr_pend.en, spr_pend.color};
            A_STAT:  rd_mux = {5'h00, irq_bit, vblank, sticky, frame_cnt};
            default: rd_mux = 16'h0000;
         endcase
      end
   end

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         rdn_q     <= 1'b1;
         vblank    <= 1'b0;
         sticky    <= 1'b0;
         frame_cnt <= 8'h00;
         spr_pend  <= '0;
         spr_act   <= '0;
         cpu_rdata <= 16'h0000;
      end else begin
         rdn_q     <= rdn;
         cpu_rdata <= rd_mux;
         if (vblank_start)
            vblank <= 1'b1;
         else if (vblank_end)
            vblank <= 1'b0;
         // Active copy takes the pre-write pending value; a same-cycle write waits a frame.
         if (vblank_start) begin
            frame_cnt <= frame_cnt + 8'd1;
            spr_act   <= spr_pend;
         end
         if (vblank_start)
            sticky <= 1'b1;
         else if (stat_wr)
            sticky <= 1'b0;
         if (cpu_we) begin
            case (cpu_addr)
               A_SPR_X: spr_pend.x <= cpu_wdata[9:0];
               A_SPR_Y: spr_pend.y <= cpu_wdata[8:0];
               A_SPR_C: begin
                  spr_pend.color <= cpu_wdata[7:0];
                  spr_pend.en    <= cpu_wdata[8];
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vga_tile_src.sv
// tb/tb_vga_tile_src.sv - randomized bench for vga_tile_src against a behavioural frame/sprite model
module tb_vga_tile_src;

   logic        vga_clk = 1'b0;
   logic        rst = 1'b1;
   logic [8:0]  row_addr = '0;
   logic [9:0]  col_addr = '0;
   logic        rdn = 1'b1;
   logic [7:0]  d_out;
   logic        cpu_we = 1'b0;
   logic [12:0] cpu_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic [15:0] cpu_rdata;
   logic        vblank;
`ifdef VGA_FRAME_IRQ_EN
   logic        irq;
   localparam int IRQ_RD = 1;
`else
   localparam int IRQ_RD = 0;
`endif

   vga_tile_src dut (
      .vga_clk  (vga_clk),
      .rst      (rst),
      .row_addr (row_addr),
      .col_addr (col_addr),
      .rdn      (rdn),
      .d_out    (d_out),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata),
`ifdef VGA_FRAME_IRQ_EN
      .irq      (irq),
`endif
      .vblank   (vblank)
   );

   always #5 vga_clk = ~vga_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   logic [7:0]  tile_m [4800];
   int m_px_p, m_py_p, m_col_p, m_en_p;
   int m_px_a, m_py_a, m_col_a, m_en_a;
   int m_fcnt, m_sticky, m_vb, m_irq, m_prev_rdn;
   logic [15:0] m_rdata;
   bit checking = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_pix(input int r, input int c, input bit rd);
      if (rd) return 8'h00;
      if (m_en_a != 0 && c >= m_px_a && c < m_px_a + 16 && r >= m_py_a && r < m_py_a + 16)
         return 8'(m_col_a);
      if (r < 480 && c < 640) return tile_m[(r / 8) * 80 + c / 8];
      return 8'h00;
   endfunction

   function automatic logic [15:0] m_rd(input int a);
      if (a < 4800) return {8'h00, tile_m[a]};
      case (a)
         'h1800:  return 16'(m_px_p);
         'h1801:  return 16'(m_py_p);
         'h1802:  return 16'(m_en_p * 256 + m_col_p);
         'h1803:  return 16'(IRQ_RD * m_irq * 1024 + m_vb * 512 + m_sticky * 256 + m_fcnt);
         default: return 16'h0000;
      endcase
   endfunction

   // Compare, then advance the model by the edge that follows.
   always @(negedge vga_clk) begin : cmp
      int  a, r, c;
      bit  vs, ve;
      if (checking) begin
         chk("d_out", {8'h00, d_out}, {8'h00, m_pix(int'(row_addr), int'(col_addr), rdn)});
         chk("vblank", {15'h0, vblank}, 16'(m_vb));
         chk("cpu_rdata", cpu_rdata, m_rdata);
`ifdef VGA_FRAME_IRQ_EN
         chk("irq", {15'h0, irq}, 16'(m_irq));
`endif
      end
      if (rst) begin
         m_px_p = 0; m_py_p = 0; m_col_p = 0; m_en_p = 0;
         m_px_a = 0; m_py_a = 0; m_col_a = 0; m_en_a = 0;
         m_fcnt = 0; m_sticky = 0; m_vb = 0; m_irq = 0; m_prev_rdn = 1;
         m_rdata = 16'h0000;
         checking = 1;
      end else if (checking) begin
         a = int'(cpu_addr);
         r = int'(row_addr);
         c = int'(col_addr);
         m_rdata = m_rd(a);
         vs = (m_prev_rdn == 0) && rdn && (r == 479);
         ve = (m_prev_rdn == 1) && !rdn && (r == 0);
         if (vs) m_sticky = 1;
         else if (cpu_we && a == 'h1803) m_sticky = 0;
         if (vs) m_irq = 1;
         else if (cpu_we && a == 'h1803 && cpu_wdata[0]) m_irq = 0;
         if (vs) begin
            m_fcnt = (m_fcnt + 1) % 256;
            m_px_a = m_px_p; m_py_a = m_py_p; m_col_a = m_col_p; m_en_a = m_en_p;
            m_vb = 1;
         end else if (ve) m_vb = 0;
         if (cpu_we) begin
            if (a < 4800) tile_m[a] = cpu_wdata[7:0];
            else case (a)
               'h1800: m_px_p = int'(cpu_wdata) % 1024;
               'h1801: m_py_p = int'(cpu_wdata) % 512;
               'h1802: begin m_col_p = int'(cpu_wdata) % 256; m_en_p = int'(cpu_wdata[8]); end
               default: ;
            endcase
         end
         m_prev_rdn = int'(rdn);
      end
   end

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic pix(input int r, input int c, input bit rd);
      row_addr = 9'(r);
      col_addr = 10'(c);
      rdn      = rd;
   endtask

   task automatic cpu_wr(input int a, input int d);
      cpu_we    = 1'b1;
      cpu_addr  = 13'(a);
      cpu_wdata = 16'(d);
      tick();
      cpu_we    = 1'b0;
   endtask

   task automatic vsync();
      pix(479, 0, 0); tick();
      pix(479, 0, 1); tick();
      pix(500, 0, 1); tick();
      pix(0, 0, 0);   tick();
   endtask

   task automatic plain_frame();
      repeat (50) begin
         pix($urandom_range(1, 478), $urandom_range(0, 639), 0);
         tick();
      end
      vsync();
   endtask

   task automatic rand_cpu();
      int sel, a;
      rst    = ($urandom % 1500 == 0);
      cpu_we = !rst && ($urandom % 3 == 0);
      sel    = $urandom % 8;
      if (sel < 4) a = $urandom_range(0, 4799);
      else if (sel < 7) a = 'h1800 + $urandom % 4;
      else begin
         a = $urandom_range('h12C0, 'h1FFF);
         if (a >= 'h1800 && a <= 'h1803) a = a + 4;
      end
      cpu_addr = 13'(a);
      case (a)
         'h1800:  cpu_wdata = 16'($urandom % 660);
         'h1801:  cpu_wdata = 16'($urandom % 500);
         'h1802:  cpu_wdata = 16'(($urandom % 4 != 0 ? 256 : 0) + $urandom % 256 + ($urandom % 128) * 512);
         default: cpu_wdata = 16'($urandom);
      endcase
   endtask

   task automatic rand_pix();
      int r, c;
      if (m_en_a != 0 && $urandom % 2 == 0) begin
         r = m_py_a + $urandom_range(0, 19) - 2;
         c = m_px_a + $urandom_range(0, 19) - 2;
      end else begin
         r = $urandom_range(0, 479);
         c = $urandom_range(0, 639);
      end
      if (r < 0) r = 0;
      if (r > 479) r = 479;
      if (c < 0) c = 0;
      if (c > 639) c = 639;
      pix(r, c, ($urandom % 8 == 0));
   endtask

   task automatic rand_frame(input int n);
      pix(0, $urandom_range(0, 639), 0); rand_cpu(); tick();
      repeat (n) begin
         rand_pix(); rand_cpu(); tick();
      end
      pix(479, $urandom_range(0, 639), 0); rand_cpu(); tick();
      pix(479, $urandom_range(0, 639), 1); rand_cpu(); tick();
      repeat (5) begin
         pix($urandom_range(480, 524), $urandom_range(0, 639), 1); rand_cpu(); tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tick(); tick();
      rst = 1'b0;
      settle();
      chk("reset_vblank", {15'h0, vblank}, 16'h0000);
      chk("reset_rdata", cpu_rdata, 16'h0000);

      for (int i = 0; i < 4800; i++) begin
         pix($urandom_range(1, 478), $urandom_range(0, 639), 0);
         cpu_wr(i, $urandom % 256);
      end
      cpu_wr(0, 'hE0);
      cpu_wr(4799, 'h1C);
      cpu_wr(80, 'h5A);
      cpu_wr(492, 'h33);
      cpu_wr(654, 'h47);
      cpu_wr(480, 'h66);

      pix(0, 5, 0);     settle(); chk("tile0", {8'h0, d_out}, 16'h00E0); tick();
      pix(0, 5, 1);     settle(); chk("rdn_hi", {8'h0, d_out}, 16'h0000); tick();
      pix(479, 639, 0); settle(); chk("tile4799", {8'h0, d_out}, 16'h001C); tick();
      pix(8, 0, 0);     settle(); chk("tile80", {8'h0, d_out}, 16'h005A); tick();

      cpu_wr('h1800, 100);
      cpu_wr('h1801, 50);
      cpu_wr('h1802, 'h1FF);
      cpu_addr = 13'h1802; tick(); settle();
      chk("rd_pend_c", cpu_rdata, 16'h01FF);
      pix(50, 100, 0); settle(); chk("spr_pending", {8'h0, d_out}, 16'h0033); tick();
      vsync();
      pix(50, 100, 0); settle(); chk("spr_tl", {8'h0, d_out}, 16'h00FF); tick();
      pix(65, 115, 0); settle(); chk("spr_br", {8'h0, d_out}, 16'h00FF); tick();
      pix(66, 116, 0); settle(); chk("spr_out", {8'h0, d_out}, 16'h0047); tick();
      pix(49, 100, 0); settle(); chk("spr_above", {8'h0, d_out}, 16'h0033); tick();

      cpu_wr('h1800, 630);
      vsync();
      for (int c = 630; c < 640; c++) begin
         pix(50, c, 0); settle(); chk("clip_in", {8'h0, d_out}, 16'h00FF); tick();
      end
      for (int c = 0; c < 6; c++) begin
         pix(50, c, 0); settle(); chk("clip_nowrap", {8'h0, d_out}, 16'h0066); tick();
      end

      pix(0, 0, 1);
      rst = 1'b1; tick(); tick();
      rst = 1'b0;
      repeat (3) plain_frame();
      cpu_addr = 13'h1803; tick(); settle();
      chk("stat_3frames", cpu_rdata, 16'(16'h0103 + IRQ_RD * 1024));
      cpu_wr('h1803, 1);
      tick(); settle();
      chk("stat_cleared", cpu_rdata, 16'h0003);

      pix(479, 0, 0); tick();
      pix(479, 0, 1);
      cpu_we = 1'b1; cpu_addr = 13'h1803; cpu_wdata = 16'h0001;
      tick();
      cpu_we = 1'b0;
      settle();
      chk("coinc_vblank", {15'h0, vblank}, 16'h0001);
`ifdef VGA_FRAME_IRQ_EN
      chk("coinc_irq", {15'h0, irq}, 16'h0001);
`endif
      tick(); settle();
      chk("coinc_sticky", cpu_rdata, 16'(16'h0304 + IRQ_RD * 1024));
      pix(0, 0, 0); tick();

      for (int f = 0; f < 30; f++)
         rand_frame(250 + $urandom % 100);
      rst    = 1'b0;
      cpu_we = 1'b0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
